// File: rtl/pbkdf2_host_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pbkdf2_host_if : packs 34 request words into one wide PBKDF2 request and
//                  serialises the 256-bit hash result as eight 32-bit words.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pbkdf2_host_if #(
  parameter int FRAME_WORDS = 34,
  parameter int HASH_WORDS  = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         word_v_i,
  input  logic [31:0]  word_i,
  output logic         word_ready_o,
  output logic         req_v_o,
  input  logic         req_ready_i,
  output logic [5:0]   salt_len_o,
  output logic [31:0]  iters_o,
  output logic [511:0] pass_o,
  output logic [511:0] salt_o,
  input  logic         hash_v_i,
  input  logic [255:0] hash_i,
  output logic         hash_ready_o,
  output logic         res_v_o,
  output logic [31:0]  res_o,
  input  logic         res_ready_i,
  output logic         err_o
);

  localparam logic [5:0] LAST_WORD = 6'(FRAME_WORDS - 1);
  localparam logic [2:0] LAST_RES  = 3'(HASH_WORDS - 1);

  typedef enum logic {REQ_COLLECT = 1'b0, REQ_ISSUE = 1'b1} req_state_e;
  typedef enum logic {RES_IDLE = 1'b0, RES_SEND = 1'b1} res_state_e;

  req_state_e     req_state_q, req_state_d;
  res_state_e     res_state_q, res_state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [2:0]     rcnt_q, rcnt_d;
  logic [5:0]     salt_len_q, salt_len_d;
  logic           w0_bad_q, w0_bad_d;
  logic [31:0]    iters_q, iters_d;
  logic [511:0]   pass_q, pass_d;
  logic [511:0]   salt_q, salt_d;
  logic           err_q, err_d;
  logic [255:0]   sh_q, sh_d;
  logic [3:0]     slot_off;

  // Words 2..17 and 18..33 share the same low-nibble slot mapping; slot 15 is the MSW.
  assign slot_off = ~(cnt_q[3:0] - 4'd2);

  always_comb begin
    req_state_d = req_state_q;
    cnt_d       = cnt_q;
    salt_len_d  = salt_len_q;
    w0_bad_d    = w0_bad_q;
    iters_d     = iters_q;
    pass_d      = pass_q;
    salt_d      = salt_q;
    err_d       = 1'b0;
    case (req_state_q)
      REQ_COLLECT: begin
        if (word_v_i) begin
          if (cnt_q == 6'd0) begin
            salt_len_d = word_i[5:0];
            w0_bad_d   = |word_i[31:6];
          end else if (cnt_q == 6'd1) begin
            iters_d = word_i;
          end else if (cnt_q < 6'd18) begin
            pass_d[{slot_off, 5'd0} +: 32] = word_i;
          end else begin
            salt_d[{slot_off, 5'd0} +: 32] = word_i;
          end
          if (cnt_q == LAST_WORD) begin
            if (!w0_bad_q && (iters_q != 32'd0)) begin
              req_state_d = REQ_ISSUE;
            end else begin
              err_d = 1'b1;
              cnt_d = 6'd0;
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      REQ_ISSUE: begin
        if (req_ready_i) begin
          req_state_d = REQ_COLLECT;
          cnt_d       = 6'd0;
        end
      end
      default: req_state_d = REQ_COLLECT;
    endcase
  end

  always_comb begin
    res_state_d = res_state_q;
    rcnt_d      = rcnt_q;
    sh_d        = sh_q;
    case (res_state_q)
      RES_IDLE: begin
        if (hash_v_i) begin
          sh_d        = hash_i;
          rcnt_d      = 3'd0;
          res_state_d = RES_SEND;
        end
      end
      RES_SEND: begin
        if (res_ready_i) begin
          sh_d = {sh_q[223:0], 32'd0};
          if (rcnt_q == LAST_RES) begin
            rcnt_d      = 3'd0;
            res_state_d = RES_IDLE;
          end else begin
            rcnt_d = rcnt_q + 3'd1;
          end
        end
      end
      default: res_state_d = RES_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_state_q <= REQ_COLLECT;
      res_state_q <= RES_IDLE;
      cnt_q       <= 6'd0;
      rcnt_q      <= 3'd0;
      salt_len_q  <= 6'd0;
      w0_bad_q    <= 1'b0;
      iters_q     <= 32'd0;
      pass_q      <= 512'd0;
      salt_q      <= 512'd0;
      err_q       <= 1'b0;
      sh_q        <= 256'd0;
    end else begin
      req_state_q <= req_state_d;
      res_state_q <= res_state_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      salt_len_q  <= salt_len_d;
      w0_bad_q    <= w0_bad_d;
      iters_q     <= iters_d;
      pass_q      <= pass_d;
      salt_q      <= salt_d;
      err_q       <= err_d;
      sh_q        <= sh_d;
    end
  end

  assign word_ready_o = ~rst_i & (req_state_q == REQ_COLLECT);
  assign hash_ready_o = ~rst_i & (res_state_q == RES_IDLE);
  assign req_v_o      = (req_state_q == REQ_ISSUE);
  assign res_v_o      = (res_state_q == RES_SEND);
  assign res_o        = sh_q[255:224];
  assign err_o        = err_q;
  assign salt_len_o   = salt_len_q;
  assign iters_o      = iters_q;
  assign pass_o       = pass_q;
  assign salt_o       = salt_q;

endmodule
`default_nettype wire

// File: tb/tb_pbkdf2_host_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pbkdf2_host_if : scoreboard bench for the PBKDF2 host adapter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pbkdf2_host_if;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         word_v_i;
  logic [31:0]  word_i;
  logic         word_ready_o;
  logic         req_v_o;
  logic         req_ready_i;
  logic [5:0]   salt_len_o;
  logic [31:0]  iters_o;
  logic [511:0] pass_o;
  logic [511:0] salt_o;
  logic         hash_v_i;
  logic [255:0] hash_i;
  logic         hash_ready_o;
  logic         res_v_o;
  logic [31:0]  res_o;
  logic         res_ready_i;
  logic         err_o;

  always #5 clk = ~clk;

  pbkdf2_host_if #(.FRAME_WORDS(34), .HASH_WORDS(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .word_v_i(word_v_i), .word_i(word_i), .word_ready_o(word_ready_o),
    .req_v_o(req_v_o), .req_ready_i(req_ready_i),
    .salt_len_o(salt_len_o), .iters_o(iters_o), .pass_o(pass_o), .salt_o(salt_o),
    .hash_v_i(hash_v_i), .hash_i(hash_i), .hash_ready_o(hash_ready_o),
    .res_v_o(res_v_o), .res_o(res_o), .res_ready_i(res_ready_i), .err_o(err_o)
  );

  typedef struct {
    logic [31:0]  w0;
    logic [31:0]  iters;
    logic [511:0] pass;
    logic [511:0] salt;
  } frame_t;

  frame_t      req_q[$];
  logic [31:0] res_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [255:0] HASH_A =
    256'h0123456789abcdef_fedcba9876543210_0011223344556677_8899aabbccddeeff;

  function automatic logic [31:0] fword(input frame_t f, input int k);
    if (k == 0) return f.w0;
    if (k == 1) return f.iters;
    if (k < 18) return f.pass[511 - 32*(k-2) -: 32];
    return f.salt[511 - 32*(k-18) -: 32];
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    f.w0    = {26'd0, 6'($urandom_range(0, 63))};
    f.iters = $urandom | 32'd1;
    for (int i = 0; i < 16; i++) begin
      f.pass[32*i +: 32] = $urandom;
      f.salt[32*i +: 32] = $urandom;
    end
    return f;
  endfunction

  task automatic send_word(input logic [31:0] w);
    int t = 0;
    word_v_i = 1'b1;
    word_i   = w;
    while (!word_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!word_ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL word_accept_timeout: word_ready_o=%b required 1 within 100 cycles", word_ready_o);
    end else begin
      @(negedge clk);
    end
    word_v_i = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input bit gaps);
    if (f.w0[31:6] == 26'd0 && f.iters != 32'd0) req_q.push_back(f);
    for (int k = 0; k < 34; k++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
      send_word(fword(f, k));
    end
  endtask

  task automatic drive_hash(input logic [255:0] h);
    int t = 0;
    while (!hash_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!hash_ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL hash_accept_timeout: hash_ready_o=%b required 1", hash_ready_o);
    end
    hash_v_i = 1'b1;
    hash_i   = h;
    @(negedge clk);
    hash_v_i = 1'b0;
    for (int i = 0; i < 8; i++) res_q.push_back(h[255 - 32*i -: 32]);
  endtask

  // Pops the oldest expected request, checks it, holds ready low for `hold` cycles, then handshakes.
  task automatic req_consume(input int hold);
    frame_t e;
    int t = 0;
    while (!req_v_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    e = req_q.pop_front();
    n_cmp++;
    if ({req_v_o, salt_len_o, iters_o} !== {1'b1, e.w0[5:0], e.iters}) begin
      n_bad++;
      $display("FAIL req_header: v/len/iters=%b/%0d/%h required 1/%0d/%h", req_v_o, salt_len_o, iters_o, 1'b1, e.w0[5:0], e.iters);
    end
    n_cmp++;
    if (pass_o !== e.pass) begin
      n_bad++;
      $display("FAIL req_pass: got %h required %h", pass_o, e.pass);
    end
    n_cmp++;
    if (salt_o !== e.salt) begin
      n_bad++;
      $display("FAIL req_salt: got %h required %h", salt_o, e.salt);
    end
    req_ready_i = 1'b0;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({req_v_o, word_ready_o, salt_len_o, iters_o, pass_o, salt_o} !==
          {1'b1, 1'b0, e.w0[5:0], e.iters, e.pass, e.salt}) begin
        n_bad++;
        $display("FAIL req_hold cycle %0d: v=%b wr=%b iters=%h required v=1 wr=0 iters=%h", c, req_v_o, word_ready_o, iters_o, e.iters);
      end
    end
    req_ready_i = 1'b1;
    @(negedge clk);
    req_ready_i = 1'b0;
    n_cmp++;
    if ({req_v_o, word_ready_o} !== 2'b01) begin
      n_bad++;
      $display("FAIL req_release: v/word_ready=%b%b required 01", req_v_o, word_ready_o);
    end
  endtask

  task automatic res_consume(input bit toggle);
    logic [31:0] e;
    for (int i = 0; i < 8; i++) begin
      int t = 0;
      while (!res_v_o && t < 50) begin
        @(negedge clk);
        t++;
      end
      e = res_q.pop_front();
      n_cmp++;
      if ({res_v_o, res_o} !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL res_word %0d: v=%b data=%h required v=1 data=%h", i, res_v_o, res_o, e);
      end
      if (toggle) begin
        res_ready_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({res_v_o, res_o} !== {1'b1, e}) begin
          n_bad++;
          $display("FAIL res_held %0d: v=%b data=%h required v=1 data=%h", i, res_v_o, res_o, e);
        end
      end
      res_ready_i = 1'b1;
      @(negedge clk);
    end
    res_ready_i = 1'b0;
    n_cmp++;
    if ({hash_ready_o, res_v_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL res_done: hash_ready/res_v=%b%b required 10", hash_ready_o, res_v_o);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({word_ready_o, hash_ready_o, req_v_o, res_v_o, err_o, salt_len_o, iters_o, res_o} !== '0
        || pass_o !== '0 || salt_o !== '0) begin
      n_bad++;
      $display("FAIL %s: wr=%b hr=%b rv=%b sv=%b err=%b len=%h it=%h res=%h required all zero",
               tag, word_ready_o, hash_ready_o, req_v_o, res_v_o, err_o, salt_len_o, iters_o, res_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; word_v_i = 1'b0; word_i = '0; req_ready_i = 1'b0;
    hash_v_i = 1'b0; hash_i = '0; res_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({word_ready_o, hash_ready_o, req_v_o, res_v_o} !== 4'b1100) begin
      n_bad++;
      $display("FAIL post_reset_ready: wr/hr/rv/sv=%b%b%b%b required 1100", word_ready_o, hash_ready_o, req_v_o, res_v_o);
    end
  endtask

  task automatic test_single_frame();
    frame_t f;
    f.w0    = 32'd16;
    f.iters = 32'd2;
    f.pass  = {64'h70617373776f7264, 448'd0};
    f.salt  = {128'h73616c74_73616c74_73616c74_73616c74, 384'd0};
    send_frame(f, 1'b0);
    req_consume(0);
  endtask

  task automatic test_backpressure();
    send_frame(rand_frame(), 1'b1);
    req_consume(10);
  endtask

  task automatic test_invalid();
    frame_t f;
    for (int v = 0; v < 2; v++) begin
      f = rand_frame();
      if (v == 0) f.iters = 32'd0;
      else        f.w0 = 32'h0000_0040;
      send_frame(f, 1'b0);
      n_cmp++;
      if ({err_o, req_v_o} !== 2'b10) begin
        n_bad++;
        $display("FAIL invalid_%0d_pulse: err/req_v=%b%b required 10", v, err_o, req_v_o);
      end
      @(negedge clk);
      n_cmp++;
      if ({err_o, req_v_o, word_ready_o} !== 3'b001) begin
        n_bad++;
        $display("FAIL invalid_%0d_after: err/req_v/word_ready=%b%b%b required 001", v, err_o, req_v_o, word_ready_o);
      end
    end
    send_frame(rand_frame(), 1'b0);
    req_consume(0);
  endtask

  task automatic test_result();
    drive_hash(HASH_A);
    n_cmp++;
    if ({res_v_o, hash_ready_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL result_start: res_v/hash_ready=%b%b required 10", res_v_o, hash_ready_o);
    end
    res_consume(1'b1);
  endtask

  task automatic test_concurrency();
    logic [255:0] h;
    send_frame(rand_frame(), 1'b0);
    req_consume(0);
    h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    drive_hash(h);
    fork
      begin
        send_frame(rand_frame(), 1'b1);
        req_consume(2);
      end
      res_consume(1'b1);
    join
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++) begin
      send_frame(rand_frame(), 1'b0);
      req_consume(0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    frame_t f;
    drive_hash(~HASH_A);
    res_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = res_q.pop_front();
      n_cmp++;
      if ({res_v_o, res_o} !== {1'b1, e}) begin
        n_bad++;
        $display("FAIL mid_res_word %0d: v=%b data=%h required v=1 data=%h", i, res_v_o, res_o, e);
      end
      @(negedge clk);
    end
    res_ready_i = 1'b0;
    f = rand_frame();
    for (int k = 0; k < 20; k++) send_word(fword(f, k));
    rst_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    rst_i = 1'b0;
    res_q.delete();
    req_q.delete();
    @(negedge clk);
    fork
      begin
        send_frame(rand_frame(), 1'b0);
        req_consume(0);
      end
      begin
        drive_hash(HASH_A);
        res_consume(1'b0);
      end
    join
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_invalid();
    test_result();
    test_concurrency();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete within 200000 ns");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
